// File: rtl/intt_butterfly.sv
// intt_butterfly: pipelined Gentleman-Sande (inverse-NTT) butterfly over Z_M.
//   x = (a + b) mod M
//   y = ((a - b) * w) mod M
//   Each result is optionally halved mod M when scale_en is set.
// The pipeline is stall-global: every stage register loads only when the
// output side can advance (out_ready, or the output register is empty).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all valid and data state
//   in_valid   input transaction present
//   in_ready   transaction accepted this cycle (combinational from out_ready)
//   a_in/b_in  coefficients, < M
//   w_in       twiddle, < M
//   scale_en   halve both results mod M, captured with the transaction
//   out_valid  result present
//   out_ready  downstream accepts the result
//   x_out      sum result, < M
//   y_out      product result, < M
module intt_butterfly #(
  parameter int unsigned data_width = 14,
  parameter int unsigned M          = 12289
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] a_in,
  input  logic [data_width-1:0] b_in,
  input  logic [data_width-1:0] w_in,
  input  logic                  scale_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] x_out,
  output logic [data_width-1:0] y_out
);

  localparam int unsigned DW = data_width;
  localparam int unsigned PW = 2 * DW;      // full product width
  localparam int unsigned MW = DW + 2;      // Barrett constant width (needs M > 2^(DW-2))
  localparam int unsigned BW = PW + MW;     // Barrett product width

  localparam logic [DW:0]   M_S = (DW + 1)'(M);
  localparam logic [PW-1:0] M_P = PW'(M);
  localparam logic [BW-1:0] M_B = BW'(M);
  localparam longint unsigned BARRETT = (64'd1 << PW) / M;
  localparam logic [MW-1:0] MU = MW'(BARRETT);

  // Global advance: the whole pipe moves when the output slot is free or draining.
  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Input capture stage
  logic [DW-1:0] r_a, r_b, r_w;
  logic          r_sc0, r_v0;

  // S1: modular sum / difference
  logic [DW-1:0] r_s1_s, r_s1_d, r_s1_w;
  logic          r_s1_sc, r_v1;

  // S2: full product
  logic [PW-1:0] r_s2_p;
  logic [DW-1:0] r_s2_s;
  logic          r_s2_sc, r_v2;

  // S3: reduced product
  logic [DW-1:0] r_s3_r, r_s3_s;
  logic          r_s3_sc, r_v3;

  // S1 combinational
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_s, w_d;

  always_comb begin
    w_sum = {1'b0, r_a} + {1'b0, r_b};
    w_s   = DW'((w_sum >= M_S) ? (w_sum - M_S) : w_sum);
    w_d   = DW'((r_a < r_b) ? ({1'b0, r_a} + M_S - {1'b0, r_b})
                            : ({1'b0, r_a} - {1'b0, r_b}));
  end

  // S3 combinational: Barrett reduction with k = PW. The quotient estimate
  // undershoots by at most 2, so the remainder is < 3M and two conditional
  // subtractions make it exact for every p < 2^PW.
  logic [MW-1:0] w_q;
  logic [PW-1:0] w_rem, w_r1, w_r2;

  always_comb begin
    w_q   = MW'((BW'(r_s2_p) * BW'(MU)) >> PW);
    w_rem = r_s2_p - PW'(BW'(w_q) * M_B);
    w_r1  = (w_rem >= M_P) ? (w_rem - M_P) : w_rem;
    w_r2  = (w_r1 >= M_P) ? (w_r1 - M_P) : w_r1;
  end

  // half(v) mod M: odd values borrow one M so the shift is exact.
  function automatic logic [DW-1:0] f_half(input logic [DW-1:0] v);
    logic [DW:0] t;
    t = v[0] ? ({1'b0, v} + M_S) : {1'b0, v};
    return DW'(t >> 1);
  endfunction

  // Operands are registered ahead of S1, so a transaction accepted at edge k
  // reaches the output register at edge k+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_w       <= '0;
      r_sc0     <= 1'b0;
      r_v0      <= 1'b0;
      r_s1_s    <= '0;
      r_s1_d    <= '0;
      r_s1_w    <= '0;
      r_s1_sc   <= 1'b0;
      r_v1      <= 1'b0;
      r_s2_p    <= '0;
      r_s2_s    <= '0;
      r_s2_sc   <= 1'b0;
      r_v2      <= 1'b0;
      r_s3_r    <= '0;
      r_s3_s    <= '0;
      r_s3_sc   <= 1'b0;
      r_v3      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      r_a       <= a_in;
      r_b       <= b_in;
      r_w       <= w_in;
      r_sc0     <= scale_en;
      r_v0      <= in_valid;

      r_s1_s    <= w_s;
      r_s1_d    <= w_d;
      r_s1_w    <= r_w;
      r_s1_sc   <= r_sc0;
      r_v1      <= r_v0;

      r_s2_p    <= PW'(r_s1_d) * PW'(r_s1_w);
      r_s2_s    <= r_s1_s;
      r_s2_sc   <= r_s1_sc;
      r_v2      <= r_v1;

      r_s3_r    <= DW'(w_r2);
      r_s3_s    <= r_s2_s;
      r_s3_sc   <= r_s2_sc;
      r_v3      <= r_v2;

      x_out     <= r_s3_sc ? f_half(r_s3_s) : r_s3_s;
      y_out     <= r_s3_sc ? f_half(r_s3_r) : r_s3_r;
      out_valid <= r_v3;
    end
  end

endmodule
